// File: rtl/mul16_seq_ctrl_pkg.sv
// rtl/mul16_seq_ctrl_pkg.sv - shared states, widths and shift constants for the 16x16 sequenced multiplier
package mul16_seq_ctrl_pkg;
    localparam int OPW   = 16;
    localparam int PRODW = 32;
    localparam int PARTW = 8;

    localparam logic [4:0] SH_P0 = 5'd0;
    localparam logic [4:0] SH_P1 = 5'd8;
    localparam logic [4:0] SH_P2 = 5'd8;
    localparam logic [4:0] SH_P3 = 5'd16;

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

    // Two's-complement magnitude; 8000h maps to 32768 as an unsigned value.
    function automatic logic [OPW-1:0] mag(input logic [OPW-1:0] v);
        return v[OPW-1] ? (~v + 16'd1) : v;
    endfunction
endpackage

// File: rtl/mul16_seq_ctrl_mul8.sv
// rtl/mul16_seq_ctrl_mul8.sv - combinational 8x8 array multiplier (Mul_8_Bit)
module Mul_8_Bit (
    input  logic        Rst,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);
    assign P = Rst ? 16'd0 : (16'(A) * 16'(B));
endmodule

// File: rtl/mul16_seq_ctrl.sv
// rtl/mul16_seq_ctrl.sv - 16x16 multiply over four 8x8 partial-product cycles
// Optional signed mode: MUL16_SIGNED_EN
module mul16_seq_ctrl
    import mul16_seq_ctrl_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [OPW-1:0]   A,
    input  logic [OPW-1:0]   B,
`ifdef MUL16_SIGNED_EN
    input  logic             Sgn,
`endif
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [PRODW-1:0] Out_P,
    output logic             Busy
);
    state_t             state, state_next;
    logic [OPW-1:0]     a_q, b_q;
    logic [PRODW-1:0]   acc;
    logic [PARTW-1:0]   mul_a, mul_b;
    logic [2*PARTW-1:0] pp;
    logic [4:0]         shamt;
    logic [PRODW-1:0]   result;
`ifdef MUL16_SIGNED_EN
    logic               neg_q;
`endif

    Mul_8_Bit u_mul (
        .Rst (Rst),
        .A   (mul_a),
        .B   (mul_b),
        .P   (pp)
    );

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        In_Ready   = 1'b0;
        Out_Valid  = 1'b0;
        Busy       = 1'b1;
        mul_a      = '0;
        mul_b      = '0;
        shamt      = SH_P0;
        case (state)
            IDLE: begin
                Busy     = 1'b0;
                In_Ready = !Rst;
                if (In_Valid) state_next = P0;
            end
            P0: begin
                mul_a = a_q[7:0];  mul_b = b_q[7:0];  shamt = SH_P0;
                state_next = P1;
            end
            P1: begin
                mul_a = a_q[7:0];  mul_b = b_q[15:8]; shamt = SH_P1;
                state_next = P2;
            end
            P2: begin
                mul_a = a_q[15:8]; mul_b = b_q[7:0];  shamt = SH_P2;
                state_next = P3;
            end
            P3: begin
                mul_a = a_q[15:8]; mul_b = b_q[15:8]; shamt = SH_P3;
                state_next = DONE;
            end
            DONE: begin
                Out_Valid = 1'b1;
                if (Out_Ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
`ifdef MUL16_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (In_Valid) begin
                    acc <= '0;
`ifdef MUL16_SIGNED_EN
                    a_q   <= Sgn ? mag(A) : A;
                    b_q   <= Sgn ? mag(B) : B;
                    neg_q <= Sgn & (A[OPW-1] ^ B[OPW-1]);
`else
                    a_q <= A;
                    b_q <= B;
`endif
                end
                P0, P1, P2, P3: acc <= acc + (PRODW'(pp) << shamt);
                default: ;
            endcase
        end
    end

`ifdef MUL16_SIGNED_EN
    assign result = neg_q ? (~acc + 32'd1) : acc;
`else
    assign result = acc;
`endif
    // Output is forced to zero outside DONE so a discarded result never leaks.
    assign Out_P = (state == DONE) ? result : '0;
endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// tb/tb_mul16_seq_ctrl.sv - directed vector bench for mul16_seq_ctrl
module tb_mul16_seq_ctrl;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Sgn = 1'b0;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [31:0] Out_P;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    mul16_seq_ctrl dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .A         (A),
        .B         (B),
`ifdef MUL16_SIGNED_EN
        .Sgn       (Sgn),
`endif
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_P     (Out_P),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[$];
    time  last_accept;
    logic have_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge after the result handshake.
    task automatic run_op(input vec_t v, input logic chk_ii);
        int cycles;
        logic [31:0] held;
        A = v.a; B = v.b; Sgn = v.sgn; In_Valid = 1'b1;
        check("in_ready_before_accept", {31'd0, In_Ready}, 32'd1);
        @(posedge Clk);
        if (chk_ii && have_last) check("initiation_interval", 32'(($time - last_accept) / 10), 32'd6);
        last_accept = $time;
        have_last = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        cycles = 1;
        while (!Out_Valid && cycles < 20) begin
            A = 16'($urandom); B = 16'($urandom); Sgn = 1'($urandom);
            @(negedge Clk);
            cycles++;
        end
        check("latency", 32'(cycles), 32'd5);
        check("product", Out_P, v.exp);
        held = Out_P;
        for (int i = 0; i < v.hold; i++) begin
            check("bp_valid", {31'd0, Out_Valid}, 32'd1);
            check("bp_stable", Out_P, held);
            check("bp_in_ready", {31'd0, In_Ready}, 32'd0);
            check("bp_busy", {31'd0, Busy}, 32'd1);
            @(negedge Clk);
        end
        Out_Ready = 1'b1;
        @(negedge Clk);
        Out_Ready = 1'b0;
        check("idle_after_accept_busy", {31'd0, Busy}, 32'd0);
        check("idle_after_accept_valid", {31'd0, Out_Valid}, 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 32'h06260060, 0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0});
        vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 32'h00000000, 3});
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 32'h00000001, 0});
        vecs.push_back('{16'h00FF, 16'hFF00, 1'b0, 32'h00FE0100, 0});
        vecs.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000, 1});
        vecs.push_back('{16'hABCD, 16'h0010, 1'b0, 32'h000ABCD0, 0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 0});
`ifdef MUL16_SIGNED_EN
        vecs.push_back('{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000, 0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 2});
        vecs.push_back('{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 0});
        vecs.push_back('{16'h0003, 16'h0004, 1'b1, 32'h0000000C, 0});
`endif
        have_last = 1'b0;
        last_accept = 0;

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        check("rst_in_ready", {31'd0, In_Ready}, 32'd0);
        check("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_out_p", Out_P, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_in_ready", {31'd0, In_Ready}, 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i], (i > 0) && (vecs[i-1].hold == 0));
        end

        // Reset during P2 discards the operation
        A = 16'h7777; B = 16'h9999; Sgn = 1'b0; In_Valid = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_out_valid", {31'd0, Out_Valid}, 32'd0);
        check("midrst_out_p", Out_P, 32'd0);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_in_ready", {31'd0, In_Ready}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        v = '{16'h0003, 16'h0004, 1'b0, 32'h0000000C, 0};
        run_op(v, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul16_seq_ctrl.md
# mul16_seq_ctrl

Sequencing controller that computes a 16x16 product by time-multiplexing the calculator's single 8x8 array multiplier over four partial-product cycles. It accepts operands over a valid/ready handshake, accumulates shifted partial products in a 32-bit register, and holds the result until the consumer accepts it. It sits between the calculator's operand/opcode front end and its result register, so the multiply path grows to 16 bits without a second array.

## Interface
- No parameters; widths are fixed at 16-bit operands and a 32-bit product.
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous and active-high.
- In_Valid  input  1  operand pair valid.
- In_Ready  output  1  controller can accept operands; high only in IDLE.
- A  input  16  multiplicand.
- B  input  16  multiplier.
- Sgn  input  1  two's-complement mode for this operation; present only with MUL16_SIGNED_EN.
- Out_Valid  output  1  Out_P holds a completed product.
- Out_Ready  input  1  consumer accepts Out_P.
- Out_P  output  32  product.
- Busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, P0, P1, P2, P3, DONE.
- IDLE:
  - In_Ready=1.
  - On In_Valid: register A and B (operand magnitudes and sign flag in signed mode), clear the accumulator, go to P0.
- Partial products, one per state; the 8x8 product is zero-extended, shifted, and added into the 32-bit accumulator:
  - P0: A[7:0]*B[7:0], shift 0.
  - P1: A[7:0]*B[15:8], shift 8.
  - P2: A[15:8]*B[7:0], shift 8.
  - P3: A[15:8]*B[15:8], shift 16.
- Arithmetic rules: accumulator is 32 bits, no carry-out beyond bit 31 is possible for 16x16 unsigned, and operands are never truncated.
- DONE:
  - Out_Valid=1. Out_P = accumulator, negated if the sign flag is set.
  - Out_P and Out_Valid stay stable while Out_Ready=0.
  - On Out_Ready=1, go to IDLE.
- In_Ready is 0 in DONE. A new operation cannot overlap an unaccepted result.
- The multiplier operand mux is driven only from the registered operands. A and B may change freely after acceptance.
- Reset (any state, including mid-sequence): state goes to IDLE, accumulator, operand registers and sign flag go to 0. Any in-flight result is discarded.
- Reset values: In_Ready=0 during the reset cycle and 1 the cycle after; Out_Valid=0, Out_P=0, Busy=0.

## Timing
- Operands are accepted on edge T where In_Valid and In_Ready are both 1.
- State sequence: P0 in cycle T+1, P1 in T+2, P2 in T+3, P3 in T+4, DONE from T+5.
- Out_Valid rises in T+5; latency is 5 cycles.
- If Out_Ready=1 in T+5, state is IDLE in T+6 and the next accept can occur at edge T+6. Minimum initiation interval is 6 cycles.
- Out_Valid and Out_Ready are combinationally independent. There is no ready-to-valid path.
- The 8x8 multiplier is combinational within one cycle. The accumulator add is registered at the end of each Pn cycle.

## Configuration
- Macro MUL16_SIGNED_EN.
- Defined:
  - Sgn port exists. With Sgn=1 at acceptance, A and B are treated as two's complement.
  - The registered magnitudes are |A| and |B|, 16-bit unsigned; 8000h maps to 32768.
  - The registered sign flag is A[15]^B[15].
  - In DONE, Out_P is the two's-complement negation of the accumulator when the sign flag is 1.
  - With Sgn=0 the operation is unsigned.
- Undefined: no Sgn port, unsigned only, and no negation logic is synthesised.

## Structure
- Shared package holds:
  - State encoding typedef (IDLE, P0–P3, DONE).
  - Partial-product shift constants (0, 8, 8, 16).
  - Width constants (operand 16, product 32, partial 8).
- One sub-module instance: the existing 8x8 array multiplier (Mul_8_Bit).
  - Its A and B inputs are driven by the byte-select mux.
  - Its Rst input is tied to this block's Rst.
- Everything else (FSM, operand registers, accumulator, sign fix-up) stays in mul16_seq_ctrl.

## Test plan
- Unsigned basic: A=1234h, B=5678h -> Out_P=06260060h with Out_Valid exactly 5 cycles after accept.
- Unsigned max: A=FFFFh, B=FFFFh -> Out_P=FFFE0001h; back-to-back operations with Out_Ready=1 run at a 6-cycle interval.
- Backpressure: hold Out_Ready=0 for 3 cycles in DONE -> Out_P and Out_Valid stable, In_Ready=0 and Busy=1 throughout, IDLE one cycle after Out_Ready=1.
- Signed (MUL16_SIGNED_EN, Sgn=1):
  - A=FFFFh, B=0002h -> Out_P=FFFFFFFEh.
  - A=8000h, B=8000h -> Out_P=40000000h.
  - A=8000h, B=0001h -> Out_P=FFFF8000h.
- Reset mid-op: assert Rst during P2 -> next cycle state is IDLE, Out_Valid=0, Out_P=0. A following A=0003h, B=0004h -> Out_P=0000000Ch.
- Operand isolation: change A and B every cycle after accept -> result still reflects the values captured at acceptance.
